// File: rtl/loader_pkg.sv
// Shared definitions for the weight-ROM loader: FSM state encoding.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/rom_loader.sv
// Streams DEPTH words into an adjacent memory in ascending address order,
// then hands the address port back to the consumer and flags done.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; consumer owns the memory address
// LOAD  | accepting words; each handshake writes one cycle later
// DRAIN | final registered write in flight, no more input accepted
// DONE  | memory contents valid; start_i begins a new pass
module rom_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int WORD_SIZE  = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [WORD_SIZE-1:0]  data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0]  mem_data_o,
  output logic                  mem_wen_o,
  output logic                  done_o
);

  loader_state_t         state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  handshake;
  logic                  last_beat;
  logic                  restart;

  assign ready_o    = (state == LOAD);
  assign done_o     = (state == DONE);
  assign handshake  = valid_i & ready_o;
  assign last_beat  = (cnt == ADDR_WIDTH'(DEPTH - 1));
  assign restart    = start_i & ((state == IDLE) | (state == DONE));
  assign mem_addr_o = mem_wen_o ? rd_addr_i : wr_addr;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = LOAD;
      LOAD:    if (handshake && last_beat) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (start_i) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter saturates at DEPTH-1 so the address never wraps back to 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt        <= '0;
      wr_addr    <= '0;
      mem_data_o <= '0;
      mem_wen_o  <= 1'b1;
    end else begin
      mem_wen_o <= 1'b1;
      if (restart) cnt <= '0;
      if (handshake) begin
        mem_wen_o  <= 1'b0;
        mem_data_o <= data_i;
        wr_addr    <= cnt;
        if (!last_beat) cnt <= cnt + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with a behavioural memory beside it that
// records every write the loader issues.
module tb_rom_loader;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [2:0] rd_addr_i;
  logic [2:0] mem_addr_o;
  logic [7:0] mem_data_o;
  logic       mem_wen_o;
  logic       done_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] tb_mem [8];
  int         wr_log [$];

  rom_loader #(.ADDR_WIDTH(3), .WORD_SIZE(8), .DEPTH(8)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .rd_addr_i  (rd_addr_i),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_wen_o  (mem_wen_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_wen_o === 1'b0) begin
      tb_mem[mem_addr_o] = mem_data_o;
      wr_log.push_back(int'(mem_addr_o));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int j = 0; j < 8; j++) tb_mem[j] = 8'h00;
    reset_i = 1'b0; start_i = 1'b0; valid_i = 1'b0; data_i = 8'h00; rd_addr_i = 3'd5;
    #2 reset_i = 1'b1;
    #1;
    chk("rst_wen", 32'(mem_wen_o), 32'h1);
    chk("rst_ready", 32'(ready_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_data", 32'(mem_data_o), 32'h0);
    chk("rst_addr_pass", 32'(mem_addr_o), 32'h5);
    cyc();
    reset_i = 1'b0;
    cyc();

    // Back-to-back load 0x10..0x17
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("load_ready", 32'(ready_o), 32'h1);
    chk("load_done_low", 32'(done_o), 32'h0);
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1; data_i = 8'(8'h10 + i);
      cyc();
      chk("b2b_wen", 32'(mem_wen_o), 32'h0);
      chk("b2b_addr", 32'(mem_addr_o), 32'(i));
      chk("b2b_data", 32'(mem_data_o), 32'(8'h10 + i));
    end
    valid_i = 1'b0;
    chk("drain_ready", 32'(ready_o), 32'h0);
    chk("drain_done", 32'(done_o), 32'h0);
    cyc();
    chk("done_high", 32'(done_o), 32'h1);
    chk("done_wen", 32'(mem_wen_o), 32'h1);
    chk("b2b_count", 32'(wr_log.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      rd_addr_i = 3'(j);
      #1;
      chk("rd_addr", 32'(mem_addr_o), 32'(j));
      chk("rd_data", 32'(tb_mem[mem_addr_o]), 32'(8'h10 + j));
    end

    // valid_i while DONE must be ignored
    valid_i = 1'b1; data_i = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("done_ign_ready", 32'(ready_o), 32'h0);
      chk("done_ign_wen", 32'(mem_wen_o), 32'h1);
    end
    valid_i = 1'b0;
    chk("done_ign_count", 32'(wr_log.size()), 32'd8);

    // Restart from DONE, reload 0x20..0x27 with gapped valid, stray start mid-load
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("restart_done_low", 32'(done_o), 32'h0);
    chk("restart_ready", 32'(ready_o), 32'h1);
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1; data_i = 8'(8'h20 + i);
      cyc();
      chk("gap_wen", 32'(mem_wen_o), 32'h0);
      chk("gap_addr", 32'(mem_addr_o), 32'(i));
      chk("gap_data", 32'(mem_data_o), 32'(8'h20 + i));
      if (i < 7) begin
        valid_i = 1'b0; data_i = 8'hEE;
        start_i = (i == 2);
        cyc();
        start_i = 1'b0;
        chk("gap_idle_wen", 32'(mem_wen_o), 32'h1);
      end
    end
    valid_i = 1'b0;
    cyc();
    chk("reload_done", 32'(done_o), 32'h1);
    chk("reload_count", 32'(wr_log.size()), 32'd16);
    for (int k = 8; k < 16; k++) chk("reload_order", 32'(wr_log[k]), 32'(k - 8));
    for (int j = 0; j < 8; j++) chk("reload_mem", 32'(tb_mem[j]), 32'(8'h20 + j));

    // Reset right after the 4th beat aborts the pass
    rd_addr_i = 3'd6;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = 8'(8'h30 + i);
      cyc();
    end
    chk("pre_rst_wen", 32'(mem_wen_o), 32'h0);
    reset_i = 1'b1;
    #1;
    chk("abort_wen", 32'(mem_wen_o), 32'h1);
    chk("abort_done", 32'(done_o), 32'h0);
    chk("abort_ready", 32'(ready_o), 32'h0);
    chk("abort_addr", 32'(mem_addr_o), 32'h6);
    cyc();
    reset_i = 1'b0;
    valid_i = 1'b1; data_i = 8'h55;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_rst_ready", 32'(ready_o), 32'h0);
      chk("post_rst_wen", 32'(mem_wen_o), 32'h1);
    end
    valid_i = 1'b0;
    chk("abort_count", 32'(wr_log.size()), 32'd19);
    for (int j = 0; j < 3; j++) chk("abort_mem_new", 32'(tb_mem[j]), 32'(8'h30 + j));
    for (int j = 3; j < 8; j++) chk("abort_mem_old", 32'(tb_mem[j]), 32'(8'h20 + j));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, memory address width.
REQ-002 SHALL have parameter WORD_SIZE, default 8, memory word width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_WIDTH, number of words loaded per pass (1..2**ADDR_WIDTH).
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  pulse to begin a load pass.
REQ-007 SHALL have port data_i  input  WORD_SIZE  incoming weight word.
REQ-008 SHALL have port valid_i  input  1  data_i valid.
REQ-009 SHALL have port ready_o  output  1  loader accepts data_i.
REQ-010 SHALL have port rd_addr_i  input  ADDR_WIDTH  consumer read address, used when not loading.
REQ-011 SHALL have port mem_addr_o  output  ADDR_WIDTH  address to memory.
REQ-012 SHALL have port mem_data_o  output  WORD_SIZE  write data to memory.
REQ-013 SHALL have port mem_wen_o  output  1  memory write enable, active-low (0 = write).
REQ-014 SHALL have port done_o  output  1  memory contents valid for reading.

Function
REQ-015 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-016 IDLE: start_i=1 -> LOAD, word counter cleared to 0, done_o cleared.
REQ-017 LOAD: ready_o=1; handshake = valid_i & ready_o.
REQ-018 On handshake, SHALL register data_i into mem_data_o and counter value into write address; mem_wen_o=0 exactly the following cycle (write latency 1 cycle).
REQ-019 Counter SHALL increment by 1 per handshake; no handshake -> mem_wen_o=1, counter holds.
REQ-020 Handshake with counter = DEPTH-1 -> DRAIN; ready_o=0 from the next cycle.
REQ-021 DRAIN: last registered write issued (mem_wen_o=0), then -> DONE next cycle.
REQ-022 DONE: done_o=1, mem_wen_o=1, ready_o=0.
REQ-023 mem_addr_o SHALL equal registered write address whenever mem_wen_o=0, else rd_addr_i (combinational pass-through).
REQ-024 start_i in LOAD or DRAIN SHALL be ignored.
REQ-025 start_i in DONE SHALL restart: -> LOAD, counter 0, done_o=0 next cycle.
REQ-026 valid_i while ready_o=0 SHALL be ignored; no write, no counter change.
REQ-027 Counter SHALL never wrap; DEPTH = 2**ADDR_WIDTH writes addresses 0..2**ADDR_WIDTH-1 exactly once.
REQ-028 Writes SHALL be in strictly ascending address order starting at 0.

Reset
REQ-029 reset_i=1 SHALL immediately force state IDLE, counter 0, ready_o=0, done_o=0, mem_wen_o=1, mem_data_o=0, write address 0.
REQ-030 Reset mid-LOAD/DRAIN SHALL abort the pass with no further writes; a new start_i is required.

Structure
REQ-031 State enum (IDLE, LOAD, DRAIN, DONE) SHALL live in shared package loader_pkg.
REQ-032 No sub-module; block SHALL sit beside ROM_inferred-style memory at integration, driving its addr/data/wen ports.

Verification (ADDR_WIDTH=3, WORD_SIZE=8, DEPTH=8)
REQ-033 start_i, then 8 back-to-back beats 0x10..0x17 -> writes addr 0..7 with data 0x10..0x17 one cycle after each beat; done_o=1 two cycles after last beat.
REQ-034 valid_i toggled 1/0 every cycle during load -> exactly 8 writes, ascending, no gaps in address; readback via rd_addr_i 0..7 returns 0x10..0x17.
REQ-035 reset_i asserted after 4th beat -> mem_wen_o=1 immediately, done_o=0, state IDLE; subsequent valid_i ignored.
REQ-036 valid_i=1 with data 0xAA in IDLE and in DONE -> ready_o=0, no write, memory unchanged.
REQ-037 start_i in DONE, reload 0x20..0x27 -> done_o drops next cycle, all 8 addresses overwritten, done_o rises again.
REQ-038 start_i pulsed mid-LOAD after beat 3 -> ignored; counter continues, load completes with 8 writes.
